// File: rtl/rf_sequencer.sv
// ---------------------------------------------------------------------------
// rf_sequencer : Moore FSM sequencing the 8x16 register file and datapath
//                strobes for MOV/ADD/CMP/AND/MVN. Optional illegal-instruction
//                trap enabled by RF_SEQUENCER_ILLEGAL_TRAP_EN.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rf_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  alu_op,
  output logic [15:0] sximm8
);

  localparam logic [2:0] S_WAIT      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_WRITE_IMM = 3'd2;
  localparam logic [2:0] S_GET_A     = 3'd3;
  localparam logic [2:0] S_GET_B     = 3'd4;
  localparam logic [2:0] S_ALU       = 3'd5;
  localparam logic [2:0] S_WRITE_REG = 3'd6;
`ifdef RF_SEQUENCER_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_HALT      = 3'd7;
`endif

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [15:0] r_ir;

  logic [2:0] w_opcode;
  logic [1:0] w_op;
  logic [2:0] w_rn;
  logic [2:0] w_rd;
  logic [1:0] w_sh;
  logic [2:0] w_rm;
  logic       w_is_movreg;
  logic       w_is_cmp;

  assign w_opcode    = r_ir[15:13];
  assign w_op        = r_ir[12:11];
  assign w_rn        = r_ir[10:8];
  assign w_rd        = r_ir[7:5];
  assign w_sh        = r_ir[4:3];
  assign w_rm        = r_ir[2:0];
  assign w_is_movreg = (w_opcode == 3'b110);
  assign w_is_cmp    = (w_opcode == 3'b101) && (w_op == 2'b01);
  assign sximm8      = {{8{r_ir[7]}}, r_ir[7:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_WAIT;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_WAIT && s)
        r_ir <= in;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_WAIT:      if (s) w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_opcode == 3'b110 && w_op == 2'b10)
          w_next_state = S_WRITE_IMM;
        else if (w_opcode == 3'b110 && w_op == 2'b00)
          w_next_state = S_GET_B;
        else if (w_opcode == 3'b101)
          w_next_state = S_GET_A;
        else
`ifdef RF_SEQUENCER_ILLEGAL_TRAP_EN
          w_next_state = S_HALT;
`else
          w_next_state = S_WAIT;
`endif
      end
      S_WRITE_IMM: w_next_state = S_WAIT;
      S_GET_A:     w_next_state = S_GET_B;
      S_GET_B:     w_next_state = S_ALU;
      S_ALU:       w_next_state = w_is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: w_next_state = S_WAIT;
`ifdef RF_SEQUENCER_ILLEGAL_TRAP_EN
      S_HALT:      w_next_state = S_HALT;
`endif
      default:     w_next_state = S_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    err      = 1'b0;
    readnum  = 3'b000;
    writenum = 3'b000;
    write    = 1'b0;
    vsel     = 2'b00;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    alu_op   = 2'b00;
    case (r_state)
      S_WAIT: w = 1'b1;
      S_WRITE_IMM: begin
        writenum = w_rn;
        vsel     = 2'b10;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift  = w_sh;
        // MOV-reg passes B through the ALU by zeroing A and adding.
        asel   = w_is_movreg;
        alu_op = w_is_movreg ? 2'b00 : w_op;
        loadc  = !w_is_cmp;
        loads  = w_is_cmp;
      end
      S_WRITE_REG: begin
        writenum = w_rd;
        write    = 1'b1;
      end
`ifdef RF_SEQUENCER_ILLEGAL_TRAP_EN
      S_HALT: err = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rf_sequencer : directed self-checking bench for rf_sequencer.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rf_sequencer;

  logic        clk;
  logic        reset_n;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic        err;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  alu_op;
  logic [15:0] sximm8;

  int checks = 0;
  int errors = 0;

  rf_sequencer dut (
    .clk(clk), .reset_n(reset_n), .s(s), .in(in), .w(w), .err(err),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .shift(shift), .alu_op(alu_op), .sximm8(sximm8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control word: w,err,readnum,writenum,write,vsel,la,lb,lc,ls,asel,bsel,shift,alu_op
  logic [20:0] obs;
  assign obs = {w, err, readnum, writenum, write, vsel, loada, loadb, loadc,
                loads, asel, bsel, shift, alu_op};

  function automatic logic [20:0] pk(input logic pw, input logic perr,
      input logic [2:0] prn, input logic [2:0] pwn, input logic pwr,
      input logic [1:0] pvs, input logic pla, input logic plb, input logic plc,
      input logic pls, input logic pas, input logic [1:0] psh,
      input logic [1:0] pop);
    return {pw, perr, prn, pwn, pwr, pvs, pla, plb, plc, pls, pas, 1'b0, psh, pop};
  endfunction

  localparam logic [20:0] IDLE = 21'h100000;  // w=1, everything else 0
  localparam logic [20:0] BUSY = 21'h000000;

  task automatic start(input logic [15:0] instr);
    @(negedge clk);
    in = instr;
    s  = 1'b1;
    @(posedge clk);
    #1;
    s  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    s = 1'b0;
    in = 16'h0000;
    #12;
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", obs, IDLE);
    end
    checks++;
    if (sximm8 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_sximm8: got %h want 0000", sximm8);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mov_imm();
    logic [20:0] e;
    start(16'hD007);
    checks++;
    if (obs !== BUSY) begin
      errors++;
      $display("FAIL movimm_decode: got %h want %h", obs, BUSY);
    end
    step();
    e = pk(0, 0, 3'd0, 3'd0, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    checks++;
    if (obs !== e || sximm8 !== 16'h0007) begin
      errors++;
      $display("FAIL movimm7_write: got %h/%h want %h/0007", obs, sximm8, e);
    end
    step();
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL movimm7_done: got %h want %h", obs, IDLE);
    end
    start(16'hD1FE);
    step();
    e = pk(0, 0, 3'd0, 3'd1, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    checks++;
    if (obs !== e || sximm8 !== 16'hFFFE) begin
      errors++;
      $display("FAIL movimm_neg_write: got %h/%h want %h/fffe", obs, sximm8, e);
    end
    step();
    checks++;
    if (w !== 1'b1) begin
      errors++;
      $display("FAIL movimm_neg_done: w got %b want 1", w);
    end
  endtask

  task automatic test_add();
    logic [20:0] exp_seq [5];
    exp_seq[0] = pk(0, 0, 3'd1, 3'd0, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    exp_seq[1] = pk(0, 0, 3'd0, 3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00);
    exp_seq[2] = pk(0, 0, 3'd0, 3'd0, 0, 2'b00, 0, 0, 1, 0, 0, 2'b01, 2'b00);
    exp_seq[3] = pk(0, 0, 3'd0, 3'd2, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    exp_seq[4] = IDLE;
    start(16'hA148);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL add_edge%0d: got %h want %h", i + 1, obs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_cmp();
    logic [20:0] exp_seq [4];
    exp_seq[0] = pk(0, 0, 3'd0, 3'd0, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    exp_seq[1] = pk(0, 0, 3'd1, 3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00);
    exp_seq[2] = pk(0, 0, 3'd0, 3'd0, 0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b01);
    exp_seq[3] = IDLE;
    start(16'hA801);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL cmp_edge%0d: got %h want %h", i + 1, obs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_mov_reg();
    logic [20:0] exp_seq [4];
    exp_seq[0] = pk(0, 0, 3'd3, 3'd0, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00);
    exp_seq[1] = pk(0, 0, 3'd0, 3'd0, 0, 2'b00, 0, 0, 1, 0, 1, 2'b10, 2'b00);
    exp_seq[2] = pk(0, 0, 3'd0, 3'd5, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    exp_seq[3] = IDLE;
    start(16'hC0B3);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs !== exp_seq[i]) begin
        errors++;
        $display("FAIL movreg_edge%0d: got %h want %h", i + 1, obs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_mvn();
    logic [20:0] e;
    start(16'hB8E2);
    step();
    step();
    step();
    e = pk(0, 0, 3'd0, 3'd0, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b11);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL mvn_alu: got %h want %h", obs, e);
    end
    step();
    step();
    checks++;
    if (w !== 1'b1) begin
      errors++;
      $display("FAIL mvn_done: w got %b want 1", w);
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] e;
    start(16'hD007);
    s  = 1'b1;
    in = 16'hD1FE;
    step();
    checks++;
    if (sximm8 !== 16'h0007 || write !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_relatch: sximm8/write got %h/%b want 0007/1", sximm8, write);
    end
    step();
    checks++;
    if (w !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wait: w got %b want 1", w);
    end
    step();
    s = 1'b0;
    checks++;
    if (w !== 1'b0 || sximm8 !== 16'hFFFE) begin
      errors++;
      $display("FAIL b2b_accept: w/sximm8 got %b/%h want 0/fffe", w, sximm8);
    end
    step();
    e = pk(0, 0, 3'd0, 3'd1, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_write: got %h want %h", obs, e);
    end
    step();
  endtask

  task automatic test_illegal();
    logic [20:0] e;
    start(16'hE000);
    step();
`ifdef RF_SEQUENCER_ILLEGAL_TRAP_EN
    e = pk(0, 1, 3'd0, 3'd0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL illegal_halt: got %h want %h", obs, e);
    end
    start(16'hD007);
    step();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL illegal_sticky: got %h want %h", obs, e);
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL illegal_reset: got %h want %h", obs, IDLE);
    end
    @(negedge clk);
    reset_n = 1'b1;
`else
    e = IDLE;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL illegal_nop: got %h want %h", obs, e);
    end
    start(16'hC800);
    checks++;
    if (obs !== BUSY) begin
      errors++;
      $display("FAIL illegal_op_decode: got %h want %h", obs, BUSY);
    end
    step();
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL illegal_op_nop: got %h want %h", obs, IDLE);
    end
`endif
  endtask

  task automatic test_reset_mid_add();
    start(16'hA148);
    step();
    step();
    checks++;
    if (loadb !== 1'b1) begin
      errors++;
      $display("FAIL midreset_getb: loadb got %b want 1", loadb);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL midreset_async: got %h want %h", obs, IDLE);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (obs !== IDLE || sximm8 !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_after: got %h/%h want %h/0000", obs, sximm8, IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mov_reg();
    test_mvn();
    test_back_to_back();
    test_illegal();
    test_reset_mid_add();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
